cla_nibble_seq_ctrl: RTL and testbench

- Multi-cycle add/subtract sequencer that drives one 4-bit carry-lookahead slice over successive nibbles of a WIDTH-bit operand pair.
- Resolves one nibble per cycle, LSB nibble first, holding the inter-nibble carry in a register.
- Sits between a requesting datapath and the shared 4-bit CLA resource, trading latency for area.
- Handshake is start/ready in, done pulse out.

---
 rtl/cla_nibble_seq_ctrl_if.sv | 27 ++
 rtl/cla_nibble_seq_ctrl.sv | 140 ++++++++++++++
 tb/tb_cla_nibble_seq_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/cla_nibble_seq_ctrl_if.sv
// Request/result bundle between a requesting datapath (master) and the
// nibble-serial add/subtract sequencer (slave).
interface cla_nibble_seq_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             sub;
    logic             cin;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] S;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, cin, A, B,
        input  ready, busy, done, S, cout, ovf
    );

    modport slave (
        input  start, sub, cin, A, B,
        output ready, busy, done, S, cout, ovf
    );
endinterface

// File: rtl/cla_nibble_seq_ctrl.sv
// Add/subtract sequencer: one 4-bit carry-lookahead slice resolves a WIDTH-bit
// operand pair one nibble per cycle, LSB first, with the inter-nibble carry held.
module cla_nibble_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cla_nibble_seq_ctrl_if.slave bus
);
    localparam int NIB = WIDTH / 4;
    localparam int CW  = $clog2(NIB);
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_load;
    logic             w_step;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_s;
    logic             r_cout;
    logic             r_ovf;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] w_a_shift;
    logic [WIDTH-1:0] w_b_shift;
    logic [4:0]       w_slice;
    logic             w_ovf;

    // 4-bit carry-lookahead slice; returns {carry_out, sum}
    function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b,
                                        input logic c0);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = a & b;
        p    = a ^ b;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        return {c[4], p ^ c[3:0]};
    endfunction

    assign w_a_shift = r_opa >> {r_cnt, 2'b00};
    assign w_b_shift = r_opb >> {r_cnt, 2'b00};
    assign w_slice   = cla4(w_a_shift[3:0], w_b_shift[3:0], r_carry);
    // Carry into the sign bit is recovered from the sign-bit sum.
    assign w_ovf     = w_slice[4] ^ (r_opa[WIDTH-1] ^ r_opb[WIDTH-1] ^ w_slice[3]);

    assign bus.ready = r_ready;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.S     = r_s;
    assign bus.cout  = r_cout;
    assign bus.ovf   = r_ovf;

    // Next-state decode and datapath strobes
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                w_step = 1'b1;
                if (r_cnt == LAST) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State, status flags, operand latches and progressive result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_opa   <= '0;
            r_opb   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_s     <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt == ST_IDLE);
            r_busy  <= (w_state_nxt == ST_RUN);
            r_done  <= (w_state_nxt == ST_DONE);
            if (w_load) begin
                r_opa   <= bus.A;
                r_opb   <= bus.sub ? ~bus.B : bus.B;
                r_carry <= bus.sub ? 1'b1 : bus.cin;
                r_cnt   <= '0;
                r_s     <= '0;
                r_cout  <= 1'b0;
                r_ovf   <= 1'b0;
            end else if (w_step) begin
                for (int n = 0; n < NIB; n++) begin
                    if (int'(r_cnt) == n) begin
                        r_s[4*n +: 4] <= w_slice[3:0];
                    end
                end
                r_carry <= w_slice[4];
                if (r_cnt == LAST) begin
                    r_cnt  <= '0;
                    r_cout <= w_slice[4];
                    r_ovf  <= w_ovf;
                end else begin
                    r_cnt  <= r_cnt + CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_cla_nibble_seq_ctrl.sv
// Directed + randomised bench for the nibble-serial add/subtract sequencer,
// with a result scoreboard drained on each done pulse.
module tb_cla_nibble_seq_ctrl;
    localparam int WIDTH = 16;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    int          checks = 0;
    int          errors = 0;
    logic [17:0] exp_q[$];
    logic [17:0] mon_e;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rs;
    logic        rci;

    cla_nibble_seq_ctrl_if #(.WIDTH(WIDTH)) bus();

    cla_nibble_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: plain wide addition, overflow from operand/result signs. Returns {ovf,cout,S}.
    function automatic logic [17:0] model(input logic s, input logic ci,
                                          input logic [15:0] a, input logic [15:0] b);
        logic [15:0] bop;
        logic [16:0] sum;
        logic        v;
        bop = s ? ~b : b;
        sum = {1'b0, a} + {1'b0, bop} + {16'd0, (s ? 1'b1 : ci)};
        v   = (a[15] == bop[15]) && (sum[15] != a[15]);
        return {v, sum[16], sum[15:0]};
    endfunction

    // Scoreboard drain on every done pulse
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            chk("sb_nonempty_at_done", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("S", 32'(bus.S), 32'(mon_e[15:0]));
                chk("cout", 32'(bus.cout), 32'(mon_e[16]));
                chk("ovf", 32'(bus.ovf), 32'(mon_e[17]));
            end
        end
    end

    // Present one request at the current negedge and check the handshake timeline.
    task automatic do_txn(input logic s, input logic ci, input logic [15:0] a,
                          input logic [15:0] b, input logic [17:0] expv);
        bus.start = 1'b1;
        bus.sub   = s;
        bus.cin   = ci;
        bus.A     = a;
        bus.B     = b;
        exp_q.push_back(expv);
        @(posedge clk);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.start = 1'b0;
                bus.sub   = ~s;
                bus.A     = 16'($urandom);
                bus.B     = 16'($urandom);
            end
            if (k <= 5) begin
                chk("busy", 32'(bus.busy), 32'(k <= 4));
                chk("done", 32'(bus.done), 32'(k == 5));
                chk("ready_low", 32'(bus.ready), 32'd0);
            end else begin
                chk("ready_after_done", 32'(bus.ready), 32'd1);
            end
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.cin   = 1'b0;
        bus.A     = 16'h0000;
        bus.B     = 16'h0000;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(bus.ready), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_S", 32'(bus.S), 32'd0);
        chk("rst_cout", 32'(bus.cout), 32'd0);
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
        rst_n = 1'b1;

        do_txn(1'b0, 1'b0, 16'h1234, 16'h4321, {1'b0, 1'b0, 16'h5555});
        do_txn(1'b0, 1'b0, 16'hFFFF, 16'h0001, {1'b0, 1'b1, 16'h0000});
        do_txn(1'b0, 1'b0, 16'h7FFF, 16'h0001, {1'b1, 1'b0, 16'h8000});
        do_txn(1'b1, 1'b1, 16'h0005, 16'h0007, {1'b0, 1'b0, 16'hFFFE});
        do_txn(1'b1, 1'b0, 16'h8000, 16'h0001, {1'b1, 1'b1, 16'h7FFF});

        // Reset during the second RUN cycle discards the partial result.
        bus.start = 1'b1;
        bus.sub   = 1'b0;
        bus.cin   = 1'b1;
        bus.A     = 16'hFFFF;
        bus.B     = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_ready", 32'(bus.ready), 32'd1);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_done", 32'(bus.done), 32'd0);
        chk("midrst_S", 32'(bus.S), 32'd0);
        chk("midrst_cout", 32'(bus.cout), 32'd0);
        chk("midrst_ovf", 32'(bus.ovf), 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("midrst_no_done", 32'(bus.done), 32'd0);
        end
        do_txn(1'b0, 1'b1, 16'h00F0, 16'h000F, {1'b0, 1'b0, 16'h0100});

        // Back-to-back: no carry leaks from the first into the second.
        do_txn(1'b0, 1'b0, 16'hFFFF, 16'h0001, {1'b0, 1'b1, 16'h0000});
        do_txn(1'b0, 1'b0, 16'h0001, 16'h0001, {1'b0, 1'b0, 16'h0002});

        // start held high with changing operands: one acceptance per NIB+2 cycles.
        for (int c = 0; c < 18; c++) begin
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            rs  = 1'($urandom_range(0, 1));
            rci = 1'($urandom_range(0, 1));
            bus.start = 1'b1;
            bus.sub   = rs;
            bus.cin   = rci;
            bus.A     = ra;
            bus.B     = rb;
            chk("held_ready", 32'(bus.ready), 32'(c % 6 == 0));
            if (c % 6 == 0) begin
                exp_q.push_back(model(rs, rci, ra, rb));
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
        chk("sb_empty_at_end", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
